// File: rtl/fir_pkg.sv
// Shared constants for the FIR control plane: register map, ap_ctrl bit positions, FSM states.
package fir_pkg;

   localparam int unsigned ADDR_AP_CTRL  = 32'h000;
   localparam int unsigned ADDR_LEN      = 32'h010;
   localparam int unsigned ADDR_CYC      = 32'h014;
   localparam int unsigned ADDR_TAP_BASE = 32'h020;

   localparam int AP_START_BIT = 0;
   localparam int AP_DONE_BIT  = 1;
   localparam int AP_IDLE_BIT  = 2;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      RUN,
      DONE
   } fir_state_e;

endpackage

// File: rtl/fir_axil_slv.sv
// AXI-Lite slave front end: turns write/read handshakes into single-cycle reg_wr/reg_rd strobes
// and returns read data two cycles after the address handshake (one cycle for tap BRAM latency).
module fir_axil_slv #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   output logic                   reg_wr,
   output logic [pADDR_WIDTH-1:0] reg_waddr,
   output logic [pDATA_WIDTH-1:0] reg_wdata,
   output logic                   reg_rd,
   output logic [pADDR_WIDTH-1:0] reg_raddr,
   input  logic [pDATA_WIDTH-1:0] rd_val,
   input  logic                   rd_bram,
   input  logic [pDATA_WIDTH-1:0] bram_do
);

   logic                   rd_pend;
   logic                   pend_bram;
   logic [pDATA_WIDTH-1:0] pend_val;

   assign wready    = awready;
   assign reg_wr    = awready && awvalid && wvalid;
   assign reg_waddr = awaddr;
   assign reg_wdata = wdata;
   assign reg_rd    = arready && arvalid;
   assign reg_raddr = araddr;

   // A read is never granted while a write is pending, so the tap BRAM port sees one master.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         awready   <= 1'b0;
         arready   <= 1'b0;
         rvalid    <= 1'b0;
         rdata     <= '0;
         rd_pend   <= 1'b0;
         pend_bram <= 1'b0;
         pend_val  <= '0;
      end else begin
         awready <= awvalid && wvalid && !awready;
         arready <= arvalid && !arready && !rd_pend && !rvalid &&
                    !(awvalid && wvalid) && !awready;
         if (reg_rd) begin
            rd_pend   <= 1'b1;
            pend_bram <= rd_bram;
            pend_val  <= rd_val;
         end else begin
            rd_pend <= 1'b0;
         end
         if (rd_pend) begin
            rvalid <= 1'b1;
            rdata  <= pend_bram ? bram_do : pend_val;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/fir_ctrl.sv
// FIR control plane: register file, tap BRAM arbitration and run sequencing.
// Optional FIR_CTRL_PERF_EN adds a read-only RUN cycle counter at 0x14.
//
// state | meaning
// IDLE  | host owns tap BRAM, waiting for ap_start
// CLEAR | zeroing data BRAM, one word per cycle
// RUN   | engine streaming, ss_en high
// DONE  | last output seen, ap_done/ap_idle set on exit
module fir_ctrl
   import fir_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst,
   input  logic                   awvalid,
   output logic                   awready,
   input  logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   wvalid,
   output logic                   wready,
   input  logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   arvalid,
   output logic                   arready,
   input  logic [pADDR_WIDTH-1:0] araddr,
   output logic                   rvalid,
   input  logic                   rready,
   output logic [pDATA_WIDTH-1:0] rdata,
   output logic [3:0]             tap_WE,
   output logic                   tap_EN,
   output logic [pDATA_WIDTH-1:0] tap_Di,
   output logic [pADDR_WIDTH-1:0] tap_A,
   input  logic [pDATA_WIDTH-1:0] tap_Do,
   input  logic                   eng_tap_EN,
   input  logic [pADDR_WIDTH-1:0] eng_tap_A,
   output logic                   clr_sel,
   output logic [3:0]             clr_WE,
   output logic [pADDR_WIDTH-1:0] clr_A,
   output logic                   eng_start,
   output logic [pDATA_WIDTH-1:0] eng_len,
   output logic                   ss_en,
   input  logic                   sm_tvalid,
   input  logic                   sm_tready,
   input  logic                   sm_tlast
);

   localparam int CNT_W = $clog2(Tape_Num + 1);
   localparam logic [pADDR_WIDTH-1:0] A_CTRL = pADDR_WIDTH'(ADDR_AP_CTRL);
   localparam logic [pADDR_WIDTH-1:0] A_LEN  = pADDR_WIDTH'(ADDR_LEN);
   localparam logic [pADDR_WIDTH-1:0] A_CYC  = pADDR_WIDTH'(ADDR_CYC);
   localparam logic [pADDR_WIDTH-1:0] A_TAP  = pADDR_WIDTH'(ADDR_TAP_BASE);

   fir_state_e             state;
   logic                   ap_start, ap_done, ap_idle;
   logic [pDATA_WIDTH-1:0] data_length;
   logic [CNT_W-1:0]       clr_cnt;
   logic                   reg_wr, reg_rd;
   logic [pADDR_WIDTH-1:0] reg_waddr, reg_raddr;
   logic [pDATA_WIDTH-1:0] reg_wdata, rd_val;
   logic                   rd_bram, busy, wr_tap, rd_tap;

   function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
      logic [31:0] w;
      w = 32'(a);
      return (w >= ADDR_TAP_BASE) && (w < ADDR_TAP_BASE + 32'(4 * Tape_Num)) &&
             (a[1:0] == 2'b00);
   endfunction

   assign busy    = (state != IDLE);
   assign wr_tap  = is_tap(reg_waddr);
   assign rd_tap  = is_tap(reg_raddr);
   assign eng_len = data_length;

   fir_axil_slv #(.pADDR_WIDTH(pADDR_WIDTH), .pDATA_WIDTH(pDATA_WIDTH)) u_slv (
      .axis_clk (axis_clk),  .axis_rst (axis_rst),
      .awvalid  (awvalid),   .awready  (awready),   .awaddr   (awaddr),
      .wvalid   (wvalid),    .wready   (wready),    .wdata    (wdata),
      .arvalid  (arvalid),   .arready  (arready),   .araddr   (araddr),
      .rvalid   (rvalid),    .rready   (rready),    .rdata    (rdata),
      .reg_wr   (reg_wr),    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
      .reg_rd   (reg_rd),    .reg_raddr(reg_raddr),
      .rd_val   (rd_val),    .rd_bram  (rd_bram),   .bram_do  (tap_Do)
   );

`ifdef FIR_CTRL_PERF_EN
   logic [31:0] cyc_cnt;

   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         cyc_cnt <= '0;
      end else if (state == CLEAR && clr_cnt == '0) begin
         cyc_cnt <= '0;
      end else if (state == RUN && cyc_cnt != 32'hFFFF_FFFF) begin
         cyc_cnt <= cyc_cnt + 32'd1;
      end
   end
`endif

   // The engine owns the tap BRAM whenever a run is in progress.
   always_comb begin
      tap_WE = 4'h0;
      tap_EN = 1'b0;
      tap_Di = '0;
      tap_A  = '0;
      if (busy) begin
         tap_EN = eng_tap_EN;
         tap_A  = eng_tap_A;
      end else if (reg_wr && wr_tap) begin
         tap_EN = 1'b1;
         tap_WE = 4'hF;
         tap_Di = reg_wdata;
         tap_A  = reg_waddr - A_TAP;
      end else if (reg_rd && rd_tap) begin
         tap_EN = 1'b1;
         tap_A  = reg_raddr - A_TAP;
      end
   end

   always_comb begin
      rd_val  = '0;
      rd_bram = 1'b0;
      if (reg_raddr == A_CTRL) begin
         rd_val[AP_START_BIT] = ap_start;
         rd_val[AP_DONE_BIT]  = ap_done;
         rd_val[AP_IDLE_BIT]  = ap_idle;
      end else if (reg_raddr == A_LEN) begin
         rd_val = data_length;
      end else if (reg_raddr == A_CYC) begin
`ifdef FIR_CTRL_PERF_EN
         rd_val = pDATA_WIDTH'(cyc_cnt);
`else
         rd_val = '0;
`endif
      end else if (rd_tap) begin
         if (busy) rd_val = '1;
         else      rd_bram = 1'b1;
      end
   end

   // Later assignments win: DONE setting ap_done overrides a same-edge read clear.
   always_ff @(posedge axis_clk) begin
      if (axis_rst) begin
         state       <= IDLE;
         ap_start    <= 1'b0;
         ap_done     <= 1'b0;
         ap_idle     <= 1'b1;
         data_length <= '0;
         clr_sel     <= 1'b0;
         clr_WE      <= 4'h0;
         clr_A       <= '0;
         clr_cnt     <= '0;
         eng_start   <= 1'b0;
         ss_en       <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         if (reg_rd && reg_raddr == A_CTRL) ap_done <= 1'b0;
         if (reg_wr && reg_waddr == A_LEN && !busy) data_length <= reg_wdata;
         case (state)
            IDLE: begin
               if (reg_wr && reg_waddr == A_CTRL && reg_wdata[AP_START_BIT]) begin
                  state    <= CLEAR;
                  ap_start <= 1'b1;
                  ap_done  <= 1'b0;
                  ap_idle  <= 1'b0;
                  clr_sel  <= 1'b1;
                  clr_WE   <= 4'hF;
                  clr_A    <= '0;
                  clr_cnt  <= CNT_W'(Tape_Num - 1);
               end
            end
            CLEAR: begin
               if (clr_cnt == '0) begin
                  state     <= RUN;
                  clr_sel   <= 1'b0;
                  clr_WE    <= 4'h0;
                  clr_A     <= '0;
                  eng_start <= 1'b1;
                  ss_en     <= 1'b1;
                  ap_start  <= 1'b0;
               end else begin
                  clr_cnt <= clr_cnt - CNT_W'(1);
                  clr_A   <= clr_A + pADDR_WIDTH'(4);
               end
            end
            RUN: begin
               if (sm_tvalid && sm_tready && sm_tlast) begin
                  state <= DONE;
                  ss_en <= 1'b0;
               end
            end
            DONE: begin
               state   <= IDLE;
               ap_done <= 1'b1;
               ap_idle <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: register-map vector table plus hand sequences for runs,
// busy arbitration, completion/ap_done semantics, optional cycle counter and mid-run reset.
module tb_fir_ctrl;

   localparam int TAPS = 11;

   logic        axis_clk, axis_rst;
   logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
   logic [11:0] awaddr, araddr, tap_A, eng_tap_A, clr_A;
   logic [31:0] wdata, rdata, tap_Di, tap_Do, eng_len;
   logic [3:0]  tap_WE, clr_WE;
   logic        tap_EN, eng_tap_EN, clr_sel, eng_start, ss_en;
   logic        sm_tvalid, sm_tready, sm_tlast;

   int tests = 0;
   int fails = 0;

   fir_ctrl dut (
      .axis_clk(axis_clk), .axis_rst(axis_rst),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata),
      .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
      .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A),
      .clr_sel(clr_sel), .clr_WE(clr_WE), .clr_A(clr_A),
      .eng_start(eng_start), .eng_len(eng_len), .ss_en(ss_en),
      .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast)
   );

   initial begin
      axis_clk = 1'b0;
      forever #5 axis_clk = ~axis_clk;
   end

   // Tap BRAM model: one-cycle read latency, read-before-write.
   logic [31:0] mem [16];
   initial for (int i = 0; i < 16; i++) mem[i] = '0;
   always @(posedge axis_clk) begin
      if (tap_EN) begin
         if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
         tap_Do <= mem[tap_A[5:2]];
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      tests++;
      fails++;
      $display("FAIL %s: handshake timeout, got none, expected response within 20 cycles", name);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      int n;
      @(negedge axis_clk);
      awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; n = 0;
      while (!awready && n < 20) begin @(negedge axis_clk); n++; end
      if (!awready) begin
         tmo("wr_handshake");
         awvalid = 1'b0; wvalid = 1'b0;
         return;
      end
      chk("wready_with_awready", 32'(wready), 32'd1);
      @(posedge axis_clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp,
                     input int hold = 0, input bit tl = 1'b0);
      int n;
      @(negedge axis_clk);
      araddr = a; arvalid = 1'b1; n = 0;
      while (!arready && n < 20) begin @(negedge axis_clk); n++; end
      if (!arready) begin
         tmo(name);
         arvalid = 1'b0;
         return;
      end
      if (tl) begin sm_tvalid = 1'b1; sm_tready = 1'b1; sm_tlast = 1'b1; end
      @(posedge axis_clk); #1;
      arvalid = 1'b0; sm_tvalid = 1'b0; sm_tready = 1'b0; sm_tlast = 1'b0;
      n = 0;
      do begin @(negedge axis_clk); n++; end while (!rvalid && n < 20);
      if (!rvalid) begin
         tmo(name);
         return;
      end
      chk({name, "_latency"}, 32'(n), 32'd2);
      for (int h = 0; h < hold; h++) begin
         @(negedge axis_clk);
         chk({name, "_rvalid_hold"}, 32'(rvalid), 32'd1);
      end
      chk(name, rdata, exp);
      rready = 1'b1;
      @(posedge axis_clk); #1;
      rready = 1'b0;
      @(negedge axis_clk);
      chk({name, "_rvalid_drop"}, 32'(rvalid), 32'd0);
   endtask

   // Start a run and check the clear sweep and the engine start pulse.
   // Returns at the negedge of the second RUN cycle.
   task automatic run_start();
      wr(12'h000, 32'h1);
      for (int i = 0; i < TAPS; i++) begin
         @(negedge axis_clk);
         chk($sformatf("clr_we_%0d", i), 32'(clr_WE), 32'hF);
         chk($sformatf("clr_a_%0d", i), 32'(clr_A), 32'(4 * i));
         chk("clr_sel_in_clear", 32'(clr_sel), 32'd1);
         chk("eng_start_in_clear", 32'(eng_start), 32'd0);
      end
      @(negedge axis_clk);
      chk("clr_we_after_clear", 32'(clr_WE), 32'd0);
      chk("clr_sel_after_clear", 32'(clr_sel), 32'd0);
      chk("eng_start_pulse", 32'(eng_start), 32'd1);
      chk("ss_en_run", 32'(ss_en), 32'd1);
      @(negedge axis_clk);
      chk("eng_start_one_cycle", 32'(eng_start), 32'd0);
   endtask

   typedef struct {
      bit          is_wr;
      logic [11:0] addr;
      logic [31:0] data;
   } vec_t;

   vec_t vq[$];
   int   tap_vals[TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
   logic [31:0] exp_cyc;

   initial begin
      axis_rst = 1'b1;
      awvalid = 0; wvalid = 0; arvalid = 0; rready = 0;
      awaddr = '0; araddr = '0; wdata = '0;
      eng_tap_EN = 0; eng_tap_A = '0;
      sm_tvalid = 0; sm_tready = 0; sm_tlast = 0;

      vq.push_back('{1'b0, 12'h000, 32'h4});
      vq.push_back('{1'b1, 12'h010, 32'd600});
      vq.push_back('{1'b0, 12'h010, 32'd600});
      for (int k = 0; k < TAPS; k++) vq.push_back('{1'b1, 12'(32'h20 + 4 * k), 32'(tap_vals[k])});
      for (int k = 0; k < TAPS; k++) vq.push_back('{1'b0, 12'(32'h20 + 4 * k), 32'(tap_vals[k])});
      vq.push_back('{1'b1, 12'h008, 32'h1234});
      vq.push_back('{1'b0, 12'h008, 32'h0});
      vq.push_back('{1'b0, 12'h04C, 32'h0});
      vq.push_back('{1'b0, 12'h014, 32'h0});
      vq.push_back('{1'b0, 12'h000, 32'h4});

      repeat (3) @(posedge axis_clk);
      @(negedge axis_clk);
      axis_rst = 1'b0;
      chk("rst_awready", 32'(awready), 32'd0);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_clr_we", 32'(clr_WE), 32'd0);
      chk("rst_clr_sel", 32'(clr_sel), 32'd0);
      chk("rst_eng_start", 32'(eng_start), 32'd0);
      chk("rst_ss_en", 32'(ss_en), 32'd0);
      chk("rst_eng_len", eng_len, 32'd0);

      foreach (vq[i]) begin
         if (vq[i].is_wr) wr(vq[i].addr, vq[i].data);
         else rd($sformatf("vec%0d_rd_%03h", i, vq[i].addr), vq[i].addr, vq[i].data);
      end
      chk("eng_len_reg", eng_len, 32'd600);
      rd("rd_hold", 12'h010, 32'd600, 4);

      // Run 1: busy arbitration, ignored restart, tlast coinciding with a status read.
      run_start();
      eng_tap_EN = 1'b1; eng_tap_A = 12'h008;
      #1;
      chk("eng_tap_a_pass", 32'(tap_A), 32'h8);
      chk("eng_tap_en_pass", 32'(tap_EN), 32'd1);
      eng_tap_EN = 1'b0; eng_tap_A = '0;
      rd("run_status", 12'h000, 32'h0);
      wr(12'h024, 32'd99);
      rd("run_tap_busy", 12'h024, 32'hFFFF_FFFF);
      wr(12'h010, 32'd5);
      rd("run_len_locked", 12'h010, 32'd600);
      wr(12'h000, 32'h1);
      @(negedge axis_clk);
      chk("no_restart_clr_sel", 32'(clr_sel), 32'd0);
      chk("no_restart_ss_en", 32'(ss_en), 32'd1);
      rd("no_restart_status", 12'h000, 32'h0);
      rd("tlast_same_edge", 12'h000, 32'h0, 0, 1'b1);
      chk("ss_en_after_done", 32'(ss_en), 32'd0);
      rd("done_status", 12'h000, 32'h6);
      rd("done_cleared", 12'h000, 32'h4);
      rd("tap_after_run", 12'h024, 32'hFFFF_FFF6);

      // Run 2: exactly 50 RUN cycles for the optional cycle counter.
      run_start();
      repeat (48) @(negedge axis_clk);
      sm_tvalid = 1'b1; sm_tready = 1'b1; sm_tlast = 1'b1;
      @(posedge axis_clk); #1;
      sm_tvalid = 1'b0; sm_tready = 1'b0; sm_tlast = 1'b0;
      @(negedge axis_clk);
      chk("ss_en_run2_done", 32'(ss_en), 32'd0);
`ifdef FIR_CTRL_PERF_EN
      exp_cyc = 32'd50;
`else
      exp_cyc = 32'd0;
`endif
      rd("cycle_count", 12'h014, exp_cyc);
      rd("run2_status", 12'h000, 32'h6);

      // Run 3: reset mid-RUN.
      run_start();
      repeat (3) @(negedge axis_clk);
      axis_rst = 1'b1;
      @(negedge axis_clk);
      axis_rst = 1'b0;
      chk("midrst_ss_en", 32'(ss_en), 32'd0);
      chk("midrst_clr_sel", 32'(clr_sel), 32'd0);
      chk("midrst_eng_len", eng_len, 32'd0);
      rd("midrst_status", 12'h000, 32'h4);
      rd("midrst_len", 12'h010, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
